ofdm_symbol_framer: RTL and testbench
=====================================

Name: ofdm_symbol_framer

Overview:
- Sits directly downstream of the Minn preamble detector and consumes its delayed 2-antenna sample stream plus the single-cycle frame_start flag.
- On each accepted frame_start it walks a fixed frame layout: optional start skip, then symbol 0 with no CP, then symbols 1..NUM_SYMBOLS-1 each with a CP.
- It discards CP and skip samples and emits only the NFFT useful samples per symbol, with symbol markers and an index, ready for the FFT stage.
- Valid-only stream, no backpressure, matching the upstream interface.

Parameters:
- INPUT_WIDTH, 12: signed I/Q sample width.
- NFFT, 2048: useful samples per symbol; must be ≥2.
- CP_LEN, 512: cyclic-prefix samples discarded before symbols 1..NUM_SYMBOLS-1; 0 allowed.
- NUM_SYMBOLS, 14: symbols per frame, including symbol 0; must be ≥1.
- START_SKIP, 0: samples discarded starting with the flagged sample, before symbol 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample strobe
- in_ch0_i / in_ch0_q / in_ch1_i / in_ch1_q  in  INPUT_WIDTH each  signed samples
- in_frame_start  in  1  marks the first sample of a frame; qualified by in_valid
- out_valid  out  1  useful sample strobe
- out_ch0_i / out_ch0_q / out_ch1_i / out_ch1_q  out  INPUT_WIDTH each  signed samples
- out_sof  out  1  first useful sample of the frame (symbol 0, sample 0)
- out_sos  out  1  first sample of each symbol
- out_eos  out  1  last sample of each symbol
- out_sym_idx  out  SYM_IDX_WIDTH = max(1, clog2(NUM_SYMBOLS))  current symbol index
- frame_done  out  1  pulse with the final out_valid of the frame
- start_dropped  out  1  pulse when a frame_start is ignored

Behaviour:
- Reset: state IDLE, all counters 0, every output 0.
- Reset asserted mid-frame aborts the frame; no frame_done is produced.
- Counting:
  - All counters advance only on in_valid.
  - Cycles without in_valid hold state.
  - All outputs are registered, with 1-cycle latency from the accepted input sample.
  - out_valid and all pulse outputs are low on any cycle where no useful sample is emitted.
  - Sample data is passed through unmodified.
- States: IDLE, SKIP, CP, DATA.
- IDLE:
  - in_valid && in_frame_start: go to SKIP if START_SKIP>0, else DATA with sym=0.
  - The flagged sample counts as skip sample 0, or as DATA sample 0 when START_SKIP=0.
  - Samples in IDLE are never emitted.
- SKIP:
  - Consumes START_SKIP samples in total, counting the flagged sample.
  - Then goes to DATA with sym=0.
- CP:
  - Consumes CP_LEN samples, then goes to DATA.
  - Never entered when CP_LEN=0.
- DATA:
  - Emits NFFT samples.
  - sample 0: out_sos=1; out_sof=1 only when sym==0.
  - sample NFFT-1: out_eos=1.
  - After the last sample: if sym==NUM_SYMBOLS-1, assert frame_done with that sample and go to IDLE.
  - Otherwise increment sym and go to CP, or straight to DATA when CP_LEN=0.
- out_sym_idx: equals sym for every emitted sample; holds its last value when out_valid=0.
- Frame_start outside IDLE:
  - Any in_valid && in_frame_start while in SKIP, CP or DATA (including the final sample of a frame) is ignored and pulses start_dropped.
  - The running frame continues unaffected.
  - No re-arm on the same sample; the next frame needs a later frame_start.
- in_frame_start without in_valid is ignored entirely, with no start_dropped.
- Counter width: clog2 of max(NFFT, CP_LEN, START_SKIP, 2), with a terminal-count compare per state.

Decomposition:
- Shared package minn_rx_pkg:
  - dual-antenna sample struct (ch0_i, ch0_q, ch1_i, ch1_q);
  - framer state enum;
  - width helper function for counter/index sizing.
- Sub-module frame_phase_counter: a reloadable terminal-count counter with an enable, reused for SKIP/CP/DATA lengths. Everything else lives in the top.

Test Plan (NFFT=8, CP_LEN=2, NUM_SYMBOLS=3, START_SKIP=1 unless noted):
- Ramp samples 0..99, continuous valid, frame_start on sample 10.
  - Outputs: samples 11-18, 21-28, 31-38, each one cycle after input.
  - sos on 11/21/31, eos on 18/28/38, sof only on 11.
  - sym_idx 0/1/2; frame_done with 38; no outputs afterwards.
- Same stimulus with in_valid deasserted every third cycle.
  - Identical sample and flag sequence.
  - out_valid never asserted on a cycle following an invalid input.
- Second frame_start on sample 25, then a third on sample 38.
  - Both ignored with start_dropped pulses.
  - The frame completes exactly as in the first case.
  - A frame_start on sample 50 starts a new frame with output from 51.
- CP_LEN=0, START_SKIP=0, frame_start on sample 5.
  - Outputs 5-28 contiguous, sos on 5/13/21, frame_done on 28.
- rst asserted while emitting sample 23.
  - All outputs 0 the next cycle, no frame_done.
  - A later frame_start on 40 produces sof on 41.
- NUM_SYMBOLS=1, frame_start with in_valid=0.
  - No activity, no start_dropped.
  - Then a valid frame_start gives a single 8-sample symbol with frame_done on its eos.

Source files
------------

// File: rtl/minn_rx_pkg.sv
// Shared types and sizing helpers for the Minn receiver chain.
package minn_rx_pkg;

    localparam int unsigned MINN_IQ_WIDTH = 12;

    typedef struct packed {
        logic signed [MINN_IQ_WIDTH-1:0] ch0_i;
        logic signed [MINN_IQ_WIDTH-1:0] ch0_q;
        logic signed [MINN_IQ_WIDTH-1:0] ch1_i;
        logic signed [MINN_IQ_WIDTH-1:0] ch1_q;
    } dual_ant_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_CP   = 2'd2,
        ST_DATA = 2'd3
    } framer_state_t;

    // Bits needed to index 0..max_val-1, never less than one.
    function automatic int unsigned minn_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/frame_phase_counter.sv
// Up-counter that reloads to zero on reaching a selectable terminal value.
module frame_phase_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_last,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_tc    = (r_count == i_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ofdm_symbol_framer.sv
// Strips start skip and cyclic prefixes from a detected frame and emits the
// useful FFT samples of each symbol with symbol markers and index.
module ofdm_symbol_framer
    import minn_rx_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 12,
    parameter int unsigned NFFT        = 2048,
    parameter int unsigned CP_LEN      = 512,
    parameter int unsigned NUM_SYMBOLS = 14,
    parameter int unsigned START_SKIP  = 0,
    localparam int unsigned SYM_IDX_WIDTH = minn_width(NUM_SYMBOLS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic signed [INPUT_WIDTH-1:0]  in_ch0_i,
    input  logic signed [INPUT_WIDTH-1:0]  in_ch0_q,
    input  logic signed [INPUT_WIDTH-1:0]  in_ch1_i,
    input  logic signed [INPUT_WIDTH-1:0]  in_ch1_q,
    input  logic                           in_frame_start,
    output logic                           out_valid,
    output logic signed [INPUT_WIDTH-1:0]  out_ch0_i,
    output logic signed [INPUT_WIDTH-1:0]  out_ch0_q,
    output logic signed [INPUT_WIDTH-1:0]  out_ch1_i,
    output logic signed [INPUT_WIDTH-1:0]  out_ch1_q,
    output logic                           out_sof,
    output logic                           out_sos,
    output logic                           out_eos,
    output logic [SYM_IDX_WIDTH-1:0]       out_sym_idx,
    output logic                           frame_done,
    output logic                           start_dropped
);

    localparam int unsigned MAX_A = (NFFT > CP_LEN) ? NFFT : CP_LEN;
    localparam int unsigned MAX_B = (MAX_A > START_SKIP) ? MAX_A : START_SKIP;
    localparam int unsigned CNT_W = minn_width(MAX_B);

    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(NFFT - 1);
    localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((START_SKIP > 0) ? START_SKIP - 1 : 0);
    localparam logic [SYM_IDX_WIDTH-1:0] SYM_LAST = SYM_IDX_WIDTH'(NUM_SYMBOLS - 1);

    framer_state_t              r_state;
    framer_state_t              w_state_nxt;
    framer_state_t              w_phase;
    logic [SYM_IDX_WIDTH-1:0]   r_sym;
    logic [SYM_IDX_WIDTH-1:0]   w_sym_nxt;
    logic [CNT_W-1:0]           w_last;
    logic [CNT_W-1:0]           w_count;
    logic                       w_tc;
    logic                       w_active;
    logic                       w_emit;
    logic                       w_sym_end;
    logic                       w_frame_end;

    // The accepted flagged sample already belongs to the first phase, so the
    // sample is classified by the phase it falls in rather than by r_state.
    assign w_active    = in_valid && ((r_state != ST_IDLE) || in_frame_start);
    assign w_phase     = (r_state == ST_IDLE) ? ((START_SKIP > 0) ? ST_SKIP : ST_DATA) : r_state;
    assign w_emit      = w_active && (w_phase == ST_DATA);
    assign w_sym_end   = w_emit && w_tc;
    assign w_frame_end = w_sym_end && (r_sym == SYM_LAST);

    always_comb begin
        w_last = DATA_LAST;
        case (w_phase)
            ST_SKIP: w_last = SKIP_LAST;
            ST_CP:   w_last = CP_LAST;
            default: w_last = DATA_LAST;
        endcase
    end

    frame_phase_counter #(
        .WIDTH (CNT_W)
    ) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_active),
        .i_last  (w_last),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sym_nxt   = r_sym;
        if (w_active) begin
            case (w_phase)
                ST_SKIP: w_state_nxt = w_tc ? ST_DATA : ST_SKIP;
                ST_CP:   w_state_nxt = w_tc ? ST_DATA : ST_CP;
                ST_DATA: begin
                    w_state_nxt = ST_DATA;
                    if (w_tc) begin
                        if (r_sym == SYM_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_sym_nxt   = '0;
                        end else begin
                            w_state_nxt = (CP_LEN > 0) ? ST_CP : ST_DATA;
                            w_sym_nxt   = r_sym + SYM_IDX_WIDTH'(1);
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sym   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sym   <= w_sym_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_ch0_i     <= '0;
            out_ch0_q     <= '0;
            out_ch1_i     <= '0;
            out_ch1_q     <= '0;
            out_sof       <= 1'b0;
            out_sos       <= 1'b0;
            out_eos       <= 1'b0;
            out_sym_idx   <= '0;
            frame_done    <= 1'b0;
            start_dropped <= 1'b0;
        end else begin
            out_valid     <= w_emit;
            out_sof       <= w_emit && (w_count == '0) && (r_sym == '0);
            out_sos       <= w_emit && (w_count == '0);
            out_eos       <= w_sym_end;
            frame_done    <= w_frame_end;
            start_dropped <= in_valid && in_frame_start && (r_state != ST_IDLE);
            if (w_emit) begin
                out_ch0_i   <= in_ch0_i;
                out_ch0_q   <= in_ch0_q;
                out_ch1_i   <= in_ch1_i;
                out_ch1_q   <= in_ch1_q;
                out_sym_idx <= r_sym;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Directed bench for ofdm_symbol_framer across three frame layouts.
module tb_ofdm_symbol_framer;

    localparam int NFFT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_frame_start = 1'b0;
    logic signed [11:0] in_ch0_i = '0, in_ch0_q = '0, in_ch1_i = '0, in_ch1_q = '0;

    logic ov_a, sof_a, sos_a, eos_a, done_a, drop_a;
    logic signed [11:0] d0i_a, d0q_a, d1i_a, d1q_a;
    logic [1:0] sym_a;
    logic ov_b, sof_b, sos_b, eos_b, done_b, drop_b;
    logic signed [11:0] d0i_b, d0q_b, d1i_b, d1q_b;
    logic [1:0] sym_b;
    logic ov_c, sof_c, sos_c, eos_c, done_c, drop_c;
    logic signed [11:0] d0i_c, d0q_c, d1i_c, d1q_c;
    logic [0:0] sym_c;

    always #5 clk = ~clk;

    ofdm_symbol_framer #(.INPUT_WIDTH(12), .NFFT(8), .CP_LEN(2), .NUM_SYMBOLS(3), .START_SKIP(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ch0_i(in_ch0_i), .in_ch0_q(in_ch0_q), .in_ch1_i(in_ch1_i), .in_ch1_q(in_ch1_q),
        .in_frame_start(in_frame_start), .out_valid(ov_a),
        .out_ch0_i(d0i_a), .out_ch0_q(d0q_a), .out_ch1_i(d1i_a), .out_ch1_q(d1q_a),
        .out_sof(sof_a), .out_sos(sos_a), .out_eos(eos_a), .out_sym_idx(sym_a),
        .frame_done(done_a), .start_dropped(drop_a));

    ofdm_symbol_framer #(.INPUT_WIDTH(12), .NFFT(8), .CP_LEN(0), .NUM_SYMBOLS(3), .START_SKIP(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ch0_i(in_ch0_i), .in_ch0_q(in_ch0_q), .in_ch1_i(in_ch1_i), .in_ch1_q(in_ch1_q),
        .in_frame_start(in_frame_start), .out_valid(ov_b),
        .out_ch0_i(d0i_b), .out_ch0_q(d0q_b), .out_ch1_i(d1i_b), .out_ch1_q(d1q_b),
        .out_sof(sof_b), .out_sos(sos_b), .out_eos(eos_b), .out_sym_idx(sym_b),
        .frame_done(done_b), .start_dropped(drop_b));

    ofdm_symbol_framer #(.INPUT_WIDTH(12), .NFFT(8), .CP_LEN(2), .NUM_SYMBOLS(1), .START_SKIP(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ch0_i(in_ch0_i), .in_ch0_q(in_ch0_q), .in_ch1_i(in_ch1_i), .in_ch1_q(in_ch1_q),
        .in_frame_start(in_frame_start), .out_valid(ov_c),
        .out_ch0_i(d0i_c), .out_ch0_q(d0q_c), .out_ch1_i(d1i_c), .out_ch1_q(d1q_c),
        .out_sof(sof_c), .out_sos(sos_c), .out_eos(eos_c), .out_sym_idx(sym_c),
        .frame_done(done_c), .start_dropped(drop_c));

    // Layout under test: which DUT is observed and where its frames begin.
    int sel = 0;
    int cfg_cp = 2;
    int cfg_nsym = 3;
    int firsts [2] = '{-1, -1};
    logic [1:0] exp_sym = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    logic        obs_valid;
    logic [4:0]  obs_flags;
    logic [1:0]  obs_sym;
    logic [47:0] obs_data;

    always_comb begin
        obs_valid = 1'b0;
        obs_flags = '0;
        obs_sym   = '0;
        obs_data  = '0;
        case (sel)
            0: begin
                obs_valid = ov_a;
                obs_flags = {sof_a, sos_a, eos_a, done_a, drop_a};
                obs_sym   = sym_a;
                obs_data  = {d0i_a, d0q_a, d1i_a, d1q_a};
            end
            1: begin
                obs_valid = ov_b;
                obs_flags = {sof_b, sos_b, eos_b, done_b, drop_b};
                obs_sym   = sym_b;
                obs_data  = {d0i_b, d0q_b, d1i_b, d1q_b};
            end
            default: begin
                obs_valid = ov_c;
                obs_flags = {sof_c, sos_c, eos_c, done_c, drop_c};
                obs_sym   = {1'b0, sym_c};
                obs_data  = {d0i_c, d0q_c, d1i_c, d1q_c};
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] sample_data(input int s);
        logic [11:0] a, b, c, d;
        a = 12'(s);
        b = 12'(-s);
        c = 12'(s + 512);
        d = 12'(1000 - s);
        return {a, b, c, d};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset valid", 64'(obs_valid), 64'd0);
        check_eq("reset flags", 64'(obs_flags), 64'd0);
        check_eq("reset sym_idx", 64'(obs_sym), 64'd0);
        check_eq("reset data", 64'(obs_data), 64'd0);
        exp_sym = '0;
        firsts = '{-1, -1};
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle and check the registered response one edge later.
    task automatic step(input bit v, input bit fs, input int s, input bit exp_drop);
        bit         e_valid;
        int         off, period, sym, pos;
        logic [4:0] e_flags;
        period = NFFT + cfg_cp;
        @(negedge clk);
        in_valid = v;
        in_frame_start = fs;
        {in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q} = sample_data(s);
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        sym = 0;
        pos = 0;
        if (v) begin
            for (int k = 0; k < 2; k++) begin
                off = s - firsts[k];
                if (firsts[k] >= 0 && off >= 0 && off < period * cfg_nsym - cfg_cp && off % period < NFFT) begin
                    e_valid = 1'b1;
                    sym = off / period;
                    pos = off % period;
                end
            end
        end
        e_flags[4] = e_valid && sym == 0 && pos == 0;
        e_flags[3] = e_valid && pos == 0;
        e_flags[2] = e_valid && pos == NFFT - 1;
        e_flags[1] = e_valid && pos == NFFT - 1 && sym == cfg_nsym - 1;
        e_flags[0] = exp_drop;
        if (e_valid) exp_sym = 2'(sym);
        check_eq($sformatf("valid s=%0d v=%0d", s, v), 64'(obs_valid), 64'(e_valid));
        check_eq($sformatf("flags s=%0d v=%0d", s, v), 64'(obs_flags), 64'(e_flags));
        check_eq($sformatf("sym_idx s=%0d v=%0d", s, v), 64'(obs_sym), 64'(exp_sym));
        if (e_valid) check_eq($sformatf("data s=%0d", s), 64'(obs_data), 64'(sample_data(s)));
    endtask

    initial begin
        // Continuous ramp, skip 1, CP 2, three symbols.
        sel = 0; cfg_cp = 2; cfg_nsym = 3;
        do_reset();
        firsts[0] = 11;
        for (int s = 0; s < 100; s++) step(1'b1, s == 10, s, 1'b0);

        // Same ramp with every third cycle invalid.
        do_reset();
        firsts[0] = 11;
        begin
            int s = 0;
            int c = 0;
            while (s < 100) begin
                if (c % 3 == 2) begin
                    step(1'b0, 1'b0, 777, 1'b0);
                end else begin
                    step(1'b1, s == 10, s, 1'b0);
                    s++;
                end
                c++;
            end
        end

        // Extra starts mid-frame and on the final sample are dropped.
        do_reset();
        firsts[0] = 11;
        firsts[1] = 51;
        for (int s = 0; s < 100; s++)
            step(1'b1, s == 10 || s == 25 || s == 38 || s == 50, s, s == 25 || s == 38);

        // No CP, no skip: contiguous symbols.
        sel = 1; cfg_cp = 0; cfg_nsym = 3;
        do_reset();
        firsts[0] = 5;
        for (int s = 0; s < 41; s++) step(1'b1, s == 5, s, 1'b0);

        // Reset in the middle of symbol 1 aborts the frame.
        sel = 0; cfg_cp = 2; cfg_nsym = 3;
        do_reset();
        firsts[0] = 11;
        for (int s = 0; s < 23; s++) step(1'b1, s == 10, s, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_frame_start = 1'b0;
        {in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q} = sample_data(23);
        @(posedge clk);
        #1;
        check_eq("rst mid valid", 64'(obs_valid), 64'd0);
        check_eq("rst mid flags", 64'(obs_flags), 64'd0);
        check_eq("rst mid sym_idx", 64'(obs_sym), 64'd0);
        check_eq("rst mid data", 64'(obs_data), 64'd0);
        exp_sym = '0;
        @(negedge clk);
        rst = 1'b0;
        firsts[0] = -1;
        firsts[1] = 41;
        for (int s = 24; s < 80; s++) step(1'b1, s == 40, s, 1'b0);

        // Single-symbol frame; unqualified starts are ignored silently.
        sel = 2; cfg_cp = 2; cfg_nsym = 1;
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 900 + k, 1'b0);
        firsts[0] = 6;
        for (int s = 0; s < 21; s++) step(1'b1, s == 5, s, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
